// File: rtl/wb_queue.sv
// Writeback queue: accepts up to two results per cycle (load first, then ALU),
// drains one per cycle to the register bank write port, exports a pending mask.
module wb_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REG      = 32,
  parameter int DEPTH        = 4,
  parameter int SELECT_WIDTH = $clog2(NUM_REG)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_src0_valid,
  input  logic [SELECT_WIDTH-1:0]     i_src0_select,
  input  logic [DATA_WIDTH-1:0]       i_src0_data,
  output logic                        o_src0_ready,
  input  logic                        i_src1_valid,
  input  logic [SELECT_WIDTH-1:0]     i_src1_select,
  input  logic [DATA_WIDTH-1:0]       i_src1_data,
  output logic                        o_src1_ready,
  output logic                        o_write_enable,
  output logic [SELECT_WIDTH-1:0]     o_write_select,
  output logic [DATA_WIDTH-1:0]       o_write_data,
  output logic [NUM_REG-1:0]          o_pending,
  output logic [$clog2(DEPTH+1)-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SELECT_WIDTH-1:0] sel_mem  [DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [DEPTH-1:0]        entry_valid;
  logic [DEPTH-1:0]        valid_next;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [PTR_W-1:0]        slot0;
  logic [CNT_W-1:0]        count;
  logic                    ready;
  logic                    pop;
  logic                    store0;
  logic                    store1;
  logic [1:0]              n_store;
  logic [NUM_REG-1:0]      pending;

  // Ready looks only at registered occupancy so it never depends on valid or the pop.
  assign ready  = rst_n && (count <= CNT_W'(DEPTH - 2));
  assign pop    = (count != '0);
  assign store1 = i_src1_valid && ready && (i_src1_select != '0);
  assign store0 = i_src0_valid && ready && (i_src0_select != '0);
  assign n_store = {1'b0, store1} + {1'b0, store0};
  // src1 goes first so that src0 wins a same-register collision.
  assign slot0  = store1 ? tail + PTR_W'(1) : tail;

  // NOTE: every variable driven in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    valid_next = entry_valid;
    if (pop)    valid_next[head]  = 1'b0;
    if (store1) valid_next[tail]  = 1'b1;
    if (store0) valid_next[slot0] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      head        <= head + PTR_W'(pop);
      tail        <= tail + PTR_W'(n_store);
      count       <= count + CNT_W'(n_store) - CNT_W'(pop);
      entry_valid <= valid_next;
    end
  end

  // NOTE: storage is not reset; entry_valid and count decide what is meaningful.
  always_ff @(posedge clk) begin
    if (store1) begin
      sel_mem[tail]  <= i_src1_select;
      data_mem[tail] <= i_src1_data;
    end
    if (store0) begin
      sel_mem[slot0]  <= i_src0_select;
      data_mem[slot0] <= i_src0_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending[sel_mem[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  assign o_src0_ready   = ready;
  assign o_src1_ready   = ready;
  assign o_write_enable = rst_n && pop;
  assign o_write_select = (rst_n && pop) ? sel_mem[head]  : '0;
  assign o_write_data   = (rst_n && pop) ? data_mem[head] : '0;
  assign o_pending      = rst_n ? pending : '0;
  assign o_count        = rst_n ? count : '0;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a queue-based reference of FIFO contents is
// advanced every edge and compared against all outputs after each edge.
module tb_wb_queue;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int SW = 5;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          src0_valid, src1_valid;
  logic [SW-1:0] src0_select, src1_select;
  logic [DW-1:0] src0_data, src1_data;
  logic          src0_ready, src1_ready;
  logic          write_enable;
  logic [SW-1:0] write_select;
  logic [DW-1:0] write_data;
  logic [NR-1:0] pending;
  logic [CW-1:0] count;

  entry_t exp_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     last_acc0, last_acc1;
  bit     pend0_seen;

  wb_queue #(.DATA_WIDTH(DW), .NUM_REG(NR), .DEPTH(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_src0_valid   (src0_valid),
    .i_src0_select  (src0_select),
    .i_src0_data    (src0_data),
    .o_src0_ready   (src0_ready),
    .i_src1_valid   (src1_valid),
    .i_src1_select  (src1_select),
    .i_src1_data    (src1_data),
    .o_src1_ready   (src1_ready),
    .o_write_enable (write_enable),
    .o_write_select (write_select),
    .o_write_data   (write_data),
    .o_pending      (pending),
    .o_count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [NR-1:0] exp_pend;
    bit            exp_rdy;
    int            sz;
    sz       = exp_q.size();
    exp_pend = '0;
    foreach (exp_q[i]) exp_pend[exp_q[i].sel] = 1'b1;
    exp_pend[0] = 1'b0;
    exp_rdy  = rst_n && (sz <= D - 2);
    if (!rst_n) begin
      sz = 0;
      exp_pend = '0;
    end
    check("count",   64'(count), 64'(sz));
    check("wen",     64'(write_enable), 64'(sz != 0));
    check("wsel",    64'(write_select), (sz != 0) ? 64'(exp_q[0].sel)  : 64'd0);
    check("wdata",   64'(write_data),   (sz != 0) ? 64'(exp_q[0].data) : 64'd0);
    check("pending", 64'(pending), 64'(exp_pend));
    check("ready0",  64'(src0_ready), 64'(exp_rdy));
    check("ready1",  64'(src1_ready), 64'(exp_rdy));
    check("cnt_max", 64'(count <= CW'(D)), 64'd1);
    if (pending[0]) pend0_seen = 1'b1;
  endtask

  // One clock: handshake decided from the reference occupancy, then the reference advances.
  task automatic cycle();
    bit rdy;
    entry_t e;
    rdy       = rst_n && (exp_q.size() <= D - 2);
    last_acc1 = src1_valid && rdy;
    last_acc0 = src0_valid && rdy;
    @(posedge clk);
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (last_acc1 && src1_select != '0) begin
        e.sel = src1_select; e.data = src1_data; exp_q.push_back(e);
      end
      if (last_acc0 && src0_select != '0) begin
        e.sel = src0_select; e.data = src0_data; exp_q.push_back(e);
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit v1, input logic [SW-1:0] s1, input logic [DW-1:0] d1,
                       input bit v0, input logic [SW-1:0] s0, input logic [DW-1:0] d0);
    src1_valid = v1; src1_select = s1; src1_data = d1;
    src0_valid = v0; src0_select = s0; src0_data = d0;
  endtask

  task automatic idle(input int n);
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int p;
    int budget;
    rst_n = 1'b0;
    pend0_seen = 1'b0;
    drive(0, '0, '0, 0, '0, '0);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    check_outputs();

    // Single write
    drive(0, '0, '0, 1, 5'd5, 32'hDEADBEEF);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    check("single_wen",  64'(write_enable), 64'd1);
    check("single_sel",  64'(write_select), 64'd5);
    check("single_data", 64'(write_data), 64'hDEADBEEF);
    check("single_pend", 64'(pending[5]), 64'd1);
    cycle();
    check("single_idle", 64'(pending), 64'd0);

    // Same-cycle dual push to one register
    drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    check("dual_first",  64'(write_data), 64'h11);
    check("dual_pend_a", 64'(pending[3]), 64'd1);
    cycle();
    check("dual_second", 64'(write_data), 64'h22);
    check("dual_pend_b", 64'(pending[3]), 64'd1);
    cycle();
    check("dual_pend_c", 64'(pending[3]), 64'd0);

    // Register 0 discard
    drive(1, 5'd7, 32'h01, 1, 5'd0, 32'hFF);
    check("r0_ready", 64'(src0_ready & src1_ready), 64'd1);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    check("r0_acc",   64'(last_acc0 & last_acc1), 64'd1);
    check("r0_count", 64'(count), 64'd1);
    check("r0_sel",   64'(write_select), 64'd7);
    idle(2);

    // Backpressure: pairs (1,2),(3,4),(5,6),(7,8), each held until accepted
    p = 0;
    budget = 0;
    while (p < 4 && budget < 50) begin
      drive(1, SW'(2 * p + 1), DW'(32'h100 + 2 * p + 1), 1, SW'(2 * p + 2), DW'(32'h100 + 2 * p + 2));
      cycle();
      if (last_acc0) p++;
      budget++;
    end
    if (p < 4) check("bp_timeout", 64'd0, 64'd1);
    check("bp_stalled", 64'(budget > 4), 64'd1);
    idle(6);
    check("bp_drained", 64'(count), 64'd0);

    // Reset mid-operation with count = 3
    drive(1, 5'd9, 32'hA9, 1, 5'd10, 32'hAA);
    cycle();
    drive(1, 5'd11, 32'hAB, 1, 5'd12, 32'hAC);
    cycle();
    check("rst_fill", 64'(count), 64'd3);
    drive(0, '0, '0, 0, '0, '0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    #1;
    check_outputs();
    check("rst_ready", 64'(src0_ready), 64'd1);
    check("rst_wen",   64'(write_enable), 64'd0);
    idle(4);

    // Pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(0, '0, '0, 1, SW'((i % 31) + 1), DW'(i));
      cycle();
    end
    idle(3);

    check("pend0_never", 64'(pend0_seen), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_queue.md
# wb_queue

Writeback queue between the execute/memory stages and the register bank write port. It accepts up to two results per cycle: src0 from the ALU and src1 from load/memory. Results are buffered in order in a DEPTH-entry FIFO, and exactly one entry per cycle drains onto the register bank's single write port. It also exports a per-register pending mask for hazard detection in decode.

## Interface
- DATA_WIDTH, 32, result / register width
- NUM_REG, 32, architectural registers; SELECT_WIDTH = $clog2(NUM_REG)
- DEPTH, 4, FIFO entries; power of two, >= 2
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- i_src0_valid  in  1  ALU result valid
- i_src0_select  in  SELECT_WIDTH  ALU destination register
- i_src0_data  in  DATA_WIDTH  ALU result
- o_src0_ready  out  1  ALU result accepted when valid && ready at the edge
- i_src1_valid / i_src1_select / i_src1_data / o_src1_ready  same as src0, for load results
- o_write_enable  out  1  to register bank write enable
- o_write_select  out  SELECT_WIDTH  to register bank write select
- o_write_data  out  DATA_WIDTH  to register bank write data
- o_pending  out  NUM_REG  bit r = 1 while any queued entry targets register r
- o_count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- **Storage.** Circular FIFO with head/tail pointers of $clog2(DEPTH) bits that wrap naturally, plus a separate count register.
- **Ready.** o_src0_ready = o_src1_ready = (DEPTH - count >= 2).
  - Computed from registered count only; no dependence on valid or on the same-cycle pop.
  - Forced 0 while rst_n = 0.
- **Push.** A source transfers on an edge where valid && ready.
  - Transfers with select == 0 are accepted (handshake completes) but not stored.
  - Both sources transferring in the same cycle: src1 is enqueued first (at tail), then src0 (at tail+1). This ordering resolves WAW on the same register: src0's value wins.
- **Pop.** Every cycle the FIFO is non-empty, the head entry is driven to the write port and removed at the edge. The register bank never stalls.
- **Write port.** Outputs are combinational from the head entry.
  - Non-empty: o_write_enable = 1, o_write_select / o_write_data = head select / data.
  - Empty: all three outputs = 0.
- **Count.** count_next = count + pushes_stored - pop, where pushes_stored ∈ {0,1,2} and pop ∈ {0,1}. Count never exceeds DEPTH by construction of ready.
- **Pending mask.** o_pending = OR over valid entries of one-hot(select). Bit 0 is always 0.
  - A register with two queued writes stays pending until both have drained.
- **Reset.** rst_n = 0 at an edge: pointers and count return to 0 and all entries are invalidated, including mid-drain. Queued data is discarded.
- **No state machine beyond occupancy.** The block is EMPTY when count = 0, DRAINING when 0 < count < DEPTH-1, and BACKPRESSURE (ready = 0) when count >= DEPTH-1.

## Timing
- **Latency.**
  - Result accepted at edge N, queue previously empty: appears on o_write_* during cycle N+1 and is written into the register bank at edge N+1.
  - With k entries ahead of it: written at edge N+1+k.
- **Throughput.** One write per cycle out, up to two per cycle in. Sustained dual-issue fills the queue and raises backpressure.
- **Ready timing.** Ready deasserts the cycle after count reaches DEPTH-1. It reasserts the cycle after count drops to DEPTH-2.
- **Pending timing.** o_pending bit rises in the cycle after the accepting edge. It falls in the cycle after the edge that pops the last entry targeting that register.
- **Values in reset.** While rst_n = 0 and in the cycle after reset: o_write_enable = 0, o_write_select = 0, o_write_data = 0, o_pending = 0, o_count = 0. Ready = 0 during reset and 1 in the cycle after.

## Test plan
- **Single write.** Reset, then src0 valid, select = 5, data = 0xDEADBEEF for one cycle.
  - Next cycle: o_write_enable = 1, select = 5, data = 0xDEADBEEF, o_pending[5] = 1.
  - Cycle after: enable = 0, pending = 0.
- **Same-cycle dual push.** src1 (select 3, data 0x11) and src0 (select 3, data 0x22) in the same cycle.
  - Writes appear on consecutive cycles: 0x11 then 0x22.
  - o_pending[3] stays 1 until after the second write.
- **Register 0 discard.** src0 select = 0, data = 0xFF and src1 select = 7, data = 0x01.
  - Both handshakes complete; only select 7 is written; o_count = 1; o_pending[0] never set.
- **Backpressure.** DEPTH = 4; both sources valid every cycle with distinct selects 1..8.
  - Ready drops when count >= 3.
  - No entry lost or reordered: writes emerge in order src1 before src0 within each pair.
  - Count never exceeds 4.
- **Reset mid-operation.** Fill to count = 3, then assert rst_n = 0 for one edge.
  - Next cycle: count = 0, o_write_enable = 0, o_pending = 0, ready = 1 once rst_n = 1.
  - No stale writes emerge afterwards.
- **Pointer wrap.** Run 20 single pushes with data = index 0..19, select = (index % 31) + 1.
  - All 20 writes emerge in order with correct data across multiple wraps of the head and tail pointers.
